// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//
// Bundles the hazard sequencer's pipeline-facing signals. clk and rst stay as
// plain module ports.
//
// master modport: the pipeline side. It drives the ID/EX/MEM status and the
//                 interrupt request, and receives the enables, flushes and
//                 interrupt-sequence controls.
// slave modport:  the hazard controller (pipe_hazard_ctrl).
//
// Signals
//   id_rsrc1, id_rsrc2        ID-stage source registers
//   id_use_src1, id_use_src2  ID instruction actually reads that source
//   ex_mem_read, ex_rdst      EX-stage load flag and destination register
//   branch_taken              branch resolved taken in EX
//   mem_req, mem_ready        data-memory access / completion
//   int_req                   external interrupt request
//   pc_we, *_we               PC and pipeline-buffer write enables
//   ifid_flush, idex_flush    load a bubble into the buffer
//   int_push, int_push_idx    stack-save cycle and which word is saved
//   int_jump, int_ack         vector jump / one-cycle acknowledge
//   mem_wait_cnt              saturating count of freeze cycles
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 8
);
  logic [REG_ADDR_W-1:0] id_rsrc1;
  logic [REG_ADDR_W-1:0] id_rsrc2;
  logic                  id_use_src1;
  logic                  id_use_src2;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rdst;
  logic                  branch_taken;
  logic                  mem_req;
  logic                  mem_ready;
  logic                  int_req;

  logic                  pc_we;
  logic                  ifid_we;
  logic                  idex_we;
  logic                  exmem_we;
  logic                  memwb_we;
  logic                  ifid_flush;
  logic                  idex_flush;
  logic                  int_push;
  logic [1:0]            int_push_idx;
  logic                  int_jump;
  logic                  int_ack;
  logic [CNT_W-1:0]      mem_wait_cnt;

  modport master (
    output id_rsrc1, id_rsrc2, id_use_src1, id_use_src2,
           ex_mem_read, ex_rdst, branch_taken,
           mem_req, mem_ready, int_req,
    input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush,
           int_push, int_push_idx, int_jump, int_ack, mem_wait_cnt
  );

  modport slave (
    input  id_rsrc1, id_rsrc2, id_use_src1, id_use_src2,
           ex_mem_read, ex_rdst, branch_taken,
           mem_req, mem_ready, int_req,
    output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush,
           int_push, int_push_idx, int_jump, int_ack, mem_wait_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB buffers and the
// PC register. It handles load-use stalls, taken-branch flushes, multi-cycle
// memory freezes and the interrupt entry sequence (drain, push, jump).
//
// Ports
//   clk  pipeline clock
//   rst  asynchronous, active-low reset; all outputs read 0 while low
//   bus  pipe_hazard_ctrl_if.slave: hazard inputs in, enables/flushes and
//        interrupt-sequence controls out (see the interface header)
//
// Parameters
//   REG_ADDR_W   register-file address width
//   DRAIN_DEPTH  bubble cycles before the interrupt push begins (>= 1)
//   PUSH_CYCLES  stack-write cycles for the PC/flags save (1..4)
//   CNT_W        width of the saturating memory-wait counter
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W  = 3,
  parameter int DRAIN_DEPTH = 3,
  parameter int PUSH_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  // The drain and push phases share one counter, sized for the longer one.
  localparam int SEQ_MAX = (DRAIN_DEPTH > PUSH_CYCLES) ? DRAIN_DEPTH : PUSH_CYCLES;
  localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;

  localparam logic [SEQ_W-1:0] DRAIN_LAST = SEQ_W'(DRAIN_DEPTH - 1);
  localparam logic [SEQ_W-1:0] PUSH_LAST  = SEQ_W'(PUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    PUSH  = 2'd2,
    JUMP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
  logic             int_pending_q, int_pending_d;
  logic [CNT_W-1:0] wait_cnt_q;

  logic [REG_ADDR_W-1:0] id_rsrc1, id_rsrc2, ex_rdst;
  logic                  freeze;
  logic                  load_use;

  assign id_rsrc1 = bus.id_rsrc1;
  assign id_rsrc2 = bus.id_rsrc2;
  assign ex_rdst  = bus.ex_rdst;

  assign freeze   = bus.mem_req & ~bus.mem_ready;
  assign load_use = bus.ex_mem_read &
                    ((bus.id_use_src1 & (id_rsrc1 == ex_rdst)) |
                     (bus.id_use_src2 & (id_rsrc2 == ex_rdst)));

  // State, sequence counter, pending flag and freeze counter. Reset aborts any
  // interrupt sequence in progress; nothing partial is completed afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      seq_cnt_q     <= '0;
      int_pending_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      seq_cnt_q     <= seq_cnt_d;
      int_pending_q <= int_pending_d;
      if (freeze && (wait_cnt_q != {CNT_W{1'b1}})) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
    end
  end

  // Next state and all enables/flushes. A freeze overrides everything: the
  // FSM holds and no buffer or PC is written. The push index keeps showing
  // the current save word during a freeze so the stack side sees it held.
  always_comb begin
    state_d          = state_q;
    seq_cnt_d        = seq_cnt_q;
    int_pending_d    = int_pending_q;

    bus.pc_we        = 1'b0;
    bus.ifid_we      = 1'b0;
    bus.idex_we      = 1'b0;
    bus.exmem_we     = 1'b0;
    bus.memwb_we     = 1'b0;
    bus.ifid_flush   = 1'b0;
    bus.idex_flush   = 1'b0;
    bus.int_push     = 1'b0;
    bus.int_push_idx = 2'd0;
    bus.int_jump     = 1'b0;
    bus.int_ack      = 1'b0;

    // A request that cannot start a sequence right now is remembered; it is
    // consumed only when DRAIN is actually entered.
    if (!freeze && (state_q == RUN) && (bus.int_req || int_pending_q)) begin
      int_pending_d = 1'b0;
    end else if (bus.int_req) begin
      int_pending_d = 1'b1;
    end

    if (state_q == PUSH) begin
      bus.int_push_idx = 2'(seq_cnt_q);
    end

    if (!freeze) begin
      bus.ifid_we  = 1'b1;
      bus.idex_we  = 1'b1;
      bus.exmem_we = 1'b1;
      bus.memwb_we = 1'b1;

      case (state_q)
        RUN: begin
          bus.pc_we = 1'b1;
          // A taken branch makes any load-use consumer wrong-path, so the
          // flush wins over the stall.
          if (bus.branch_taken) begin
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
          end else if (load_use) begin
            bus.pc_we      = 1'b0;
            bus.ifid_we    = 1'b0;
            bus.idex_flush = 1'b1;
          end
          if (bus.int_req || int_pending_q) begin
            state_d   = DRAIN;
            seq_cnt_d = '0;
          end
        end

        DRAIN: begin
          bus.ifid_flush = 1'b1;
          // A branch resolving while draining must still redirect the PC so
          // the saved return address is the branch target.
          if (bus.branch_taken) begin
            bus.pc_we      = 1'b1;
            bus.idex_flush = 1'b1;
          end
          if (seq_cnt_q == DRAIN_LAST) begin
            state_d   = PUSH;
            seq_cnt_d = '0;
          end else begin
            seq_cnt_d = seq_cnt_q + 1'b1;
          end
        end

        PUSH: begin
          bus.ifid_flush = 1'b1;
          bus.idex_flush = 1'b1;
          bus.int_push   = 1'b1;
          if (seq_cnt_q == PUSH_LAST) begin
            state_d   = JUMP;
            seq_cnt_d = '0;
          end else begin
            seq_cnt_d = seq_cnt_q + 1'b1;
          end
        end

        JUMP: begin
          bus.pc_we      = 1'b1;
          bus.ifid_flush = 1'b1;
          bus.idex_flush = 1'b1;
          bus.int_jump   = 1'b1;
          bus.int_ack    = 1'b1;
          state_d        = RUN;
        end

        default: begin
          state_d   = RUN;
          seq_cnt_d = '0;
        end
      endcase
    end

    // Outputs read 0 for as long as reset is held.
    if (!rst) begin
      bus.pc_we        = 1'b0;
      bus.ifid_we      = 1'b0;
      bus.idex_we      = 1'b0;
      bus.exmem_we     = 1'b0;
      bus.memwb_we     = 1'b0;
      bus.ifid_flush   = 1'b0;
      bus.idex_flush   = 1'b0;
      bus.int_push     = 1'b0;
      bus.int_push_idx = 2'd0;
      bus.int_jump     = 1'b0;
      bus.int_ack      = 1'b0;
    end
  end

  assign bus.mem_wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl with default parameters. Inputs change
// 1 time unit after a rising edge; the combinational outputs are compared
// 1 unit later, well clear of the next edge.
//
// Output vector layout used by the expected constants (MSB first):
//   pc_we ifid_we idex_we exmem_we memwb_we ifid_flush idex_flush
//   int_push int_jump int_ack
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(3), .CNT_W(8)) bus ();

  pipe_hazard_ctrl #(
    .REG_ADDR_W (3),
    .DRAIN_DEPTH(3),
    .PUSH_CYCLES(2),
    .CNT_W      (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [9:0] O_ZERO  = 10'b00000_00_000;
  localparam logic [9:0] O_RUN   = 10'b11111_00_000;
  localparam logic [9:0] O_LU    = 10'b00111_01_000;
  localparam logic [9:0] O_BR    = 10'b11111_11_000;
  localparam logic [9:0] O_DRAIN = 10'b01111_10_000;
  localparam logic [9:0] O_PUSH  = 10'b01111_11_100;
  localparam logic [9:0] O_JUMP  = 10'b11111_11_011;

  function automatic logic [9:0] get_outs();
    return {bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we, bus.memwb_we,
            bus.ifid_flush, bus.idex_flush,
            bus.int_push, bus.int_jump, bus.int_ack};
  endfunction

  task automatic set_idle();
    bus.id_rsrc1     = 3'd0;
    bus.id_rsrc2     = 3'd0;
    bus.id_use_src1  = 1'b0;
    bus.id_use_src2  = 1'b0;
    bus.ex_mem_read  = 1'b0;
    bus.ex_rdst      = 3'd0;
    bus.branch_taken = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_ready    = 1'b0;
    bus.int_req      = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_idle();
    #1;
    checks++;
    if (get_outs() !== O_ZERO) begin
      failures++;
      $display("[TB] FAIL reset_outs got=%b exp=%b", get_outs(), O_ZERO);
    end
    checks++;
    if (bus.mem_wait_cnt !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_wait_cnt got=%0d exp=0", bus.mem_wait_cnt);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (get_outs() !== O_RUN) begin
      failures++;
      $display("[TB] FAIL reset_release_run got=%b exp=%b", get_outs(), O_RUN);
    end
    tick();
  endtask

  task automatic test_load_use();
    // 0: rsrc1 hazard, 1: idle, 2: rsrc2 hazard,
    // 3: match but not used, 4: match but EX is not a load
    logic [9:0] exp_tab [5] = '{O_LU, O_RUN, O_LU, O_RUN, O_RUN};
    for (int i = 0; i < 5; i++) begin
      set_idle();
      case (i)
        0: begin bus.ex_mem_read = 1; bus.ex_rdst = 3; bus.id_rsrc1 = 3; bus.id_use_src1 = 1; end
        2: begin bus.ex_mem_read = 1; bus.ex_rdst = 5; bus.id_rsrc1 = 2; bus.id_rsrc2 = 5;
                 bus.id_use_src1 = 1; bus.id_use_src2 = 1; end
        3: begin bus.ex_mem_read = 1; bus.ex_rdst = 4; bus.id_rsrc1 = 4; bus.id_use_src1 = 0;
                 bus.id_rsrc2 = 1; bus.id_use_src2 = 1; end
        4: begin bus.ex_mem_read = 0; bus.ex_rdst = 6; bus.id_rsrc1 = 6; bus.id_use_src1 = 1; end
        default: ;
      endcase
      #1;
      checks++;
      if (get_outs() !== exp_tab[i]) begin
        failures++;
        $display("[TB] FAIL load_use_%0d got=%b exp=%b", i, get_outs(), exp_tab[i]);
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_branch_load_use();
    set_idle();
    bus.ex_mem_read  = 1;
    bus.ex_rdst      = 3;
    bus.id_rsrc1     = 3;
    bus.id_use_src1  = 1;
    bus.branch_taken = 1;
    #1;
    checks++;
    if (get_outs() !== O_BR) begin
      failures++;
      $display("[TB] FAIL branch_over_load_use got=%b exp=%b", get_outs(), O_BR);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (get_outs() !== O_RUN) begin
      failures++;
      $display("[TB] FAIL after_branch got=%b exp=%b", get_outs(), O_RUN);
    end
    tick();
  endtask

  task automatic test_freeze();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    set_idle();
    bus.mem_req   = 1;
    bus.mem_ready = 0;
    bus.branch_taken = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (get_outs() !== O_ZERO || bus.mem_wait_cnt !== 8'(i)) begin
        failures++;
        $display("[TB] FAIL freeze_%0d got=%b cnt=%0d exp=%b cnt=%0d",
                 i, get_outs(), bus.mem_wait_cnt, O_ZERO, i);
      end
      tick();
    end
    bus.mem_ready    = 1;
    bus.branch_taken = 0;
    #1;
    checks++;
    if (get_outs() !== O_RUN || bus.mem_wait_cnt !== 8'd4) begin
      failures++;
      $display("[TB] FAIL freeze_release got=%b cnt=%0d exp=%b cnt=4",
               get_outs(), bus.mem_wait_cnt, O_RUN);
    end
    tick();
    bus.mem_ready = 0;
    for (int i = 0; i < 300; i++) tick();
    checks++;
    if (bus.mem_wait_cnt !== 8'd255) begin
      failures++;
      $display("[TB] FAIL freeze_saturate got=%0d exp=255", bus.mem_wait_cnt);
    end
    set_idle();
    tick();
    checks++;
    if (bus.mem_wait_cnt !== 8'd255 || get_outs() !== O_RUN) begin
      failures++;
      $display("[TB] FAIL freeze_saturate_hold got=%b cnt=%0d exp=%b cnt=255",
               get_outs(), bus.mem_wait_cnt, O_RUN);
    end
    tick();
  endtask

  task automatic test_interrupt();
    logic [9:0] exp_tab [8] = '{O_RUN, O_DRAIN, O_DRAIN, O_DRAIN,
                                O_PUSH, O_PUSH, O_JUMP, O_RUN};
    logic [1:0] exp_idx [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      set_idle();
      bus.int_req = (i == 0);
      #1;
      checks++;
      if (get_outs() !== exp_tab[i] || bus.int_push_idx !== exp_idx[i]) begin
        failures++;
        $display("[TB] FAIL interrupt_cyc%0d got=%b idx=%0d exp=%b idx=%0d",
                 i, get_outs(), bus.int_push_idx, exp_tab[i], exp_idx[i]);
      end
      tick();
    end
  endtask

  task automatic test_freeze_push();
    logic [9:0] exp_tab [10] = '{O_RUN, O_DRAIN, O_DRAIN, O_DRAIN, O_PUSH,
                                 O_ZERO, O_ZERO, O_PUSH, O_JUMP, O_RUN};
    logic [1:0] exp_idx [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    for (int i = 0; i < 10; i++) begin
      set_idle();
      bus.int_req   = (i == 0);
      bus.mem_req   = (i == 5 || i == 6);
      bus.mem_ready = 1'b0;
      #1;
      checks++;
      if (get_outs() !== exp_tab[i] || bus.int_push_idx !== exp_idx[i]) begin
        failures++;
        $display("[TB] FAIL freeze_push_cyc%0d got=%b idx=%0d exp=%b idx=%0d",
                 i, get_outs(), bus.int_push_idx, exp_tab[i], exp_idx[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_tab [15] = '{O_RUN, O_DRAIN, O_DRAIN, O_DRAIN, O_PUSH,
                                 O_PUSH, O_JUMP, O_RUN, O_DRAIN, O_DRAIN,
                                 O_DRAIN, O_PUSH, O_PUSH, O_JUMP, O_RUN};
    logic [1:0] exp_idx [15] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 15; i++) begin
      set_idle();
      bus.int_req = (i == 0 || i == 4);
      #1;
      checks++;
      if (get_outs() !== exp_tab[i] || bus.int_push_idx !== exp_idx[i]) begin
        failures++;
        $display("[TB] FAIL back_to_back_cyc%0d got=%b idx=%0d exp=%b idx=%0d",
                 i, get_outs(), bus.int_push_idx, exp_tab[i], exp_idx[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_drain();
    set_idle();
    bus.int_req = 1;
    #1;
    checks++;
    if (get_outs() !== O_RUN) begin
      failures++;
      $display("[TB] FAIL mid_reset_entry got=%b exp=%b", get_outs(), O_RUN);
    end
    tick();
    // In DRAIN: a taken branch redirects the PC; the second request goes pending.
    bus.int_req      = 1;
    bus.branch_taken = 1;
    #1;
    checks++;
    if (get_outs() !== O_BR) begin
      failures++;
      $display("[TB] FAIL drain_branch got=%b exp=%b", get_outs(), O_BR);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (get_outs() !== O_DRAIN) begin
      failures++;
      $display("[TB] FAIL drain_plain got=%b exp=%b", get_outs(), O_DRAIN);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (get_outs() !== O_ZERO || bus.int_push_idx !== 2'd0 || bus.mem_wait_cnt !== 8'd0) begin
      failures++;
      $display("[TB] FAIL async_reset got=%b idx=%0d cnt=%0d exp=%b idx=0 cnt=0",
               get_outs(), bus.int_push_idx, bus.mem_wait_cnt, O_ZERO);
    end
    tick();
    checks++;
    if (get_outs() !== O_ZERO) begin
      failures++;
      $display("[TB] FAIL reset_held got=%b exp=%b", get_outs(), O_ZERO);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (get_outs() !== O_RUN) begin
        failures++;
        $display("[TB] FAIL post_reset_run_%0d got=%b exp=%b", i, get_outs(), O_RUN);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_load_use();
    test_freeze();
    test_interrupt();
    test_freeze_push();
    test_back_to_back();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencer for the five-stage pipeline buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register. It generates per-buffer write enables and flushes to handle four conditions: load-use stalls, branch flushes, multi-cycle memory freezes, and interrupt entry. Interrupt entry is a drain/push/jump sequence. Outputs drive the buffers' write_enable ports and the fetch-stage PC enable directly.

Parameters:
REG_ADDR_W, 3, width of register-file addresses
DRAIN_DEPTH, 3, bubble cycles inserted before the interrupt push begins
PUSH_CYCLES, 2, stack-write cycles for PC/flags save (1..4)
CNT_W, 8, width of the saturating memory-wait counter

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-low reset
id_rsrc1  in  REG_ADDR_W  ID-stage source register 1
id_rsrc2  in  REG_ADDR_W  ID-stage source register 2
id_use_src1  in  1  ID instruction reads rsrc1
id_use_src2  in  1  ID instruction reads rsrc2
ex_mem_read  in  1  EX-stage instruction is a load
ex_rdst  in  REG_ADDR_W  EX-stage destination register
branch_taken  in  1  branch resolved taken in EX this cycle
mem_req  in  1  MEM stage accessing data memory
mem_ready  in  1  data memory completes access this cycle
int_req  in  1  external interrupt, sampled on posedge clk
pc_we  out  1  PC write enable
ifid_we, idex_we, exmem_we, memwb_we  out  1 each  buffer write enables
ifid_flush, idex_flush  out  1 each  load bubble (zeros) into buffer
int_push  out  1  stack-save cycle active
int_push_idx  out  2  which save word (0 = PC, 1 = flags, ...)
int_jump  out  1  load PC from interrupt vector
int_ack  out  1  one-cycle acknowledge
mem_wait_cnt  out  CNT_W  cumulative freeze cycles, saturating

Behaviour:
- Reset: rst=0 asynchronously forces state RUN and clears int_pending, the drain/push counter and mem_wait_cnt. While rst=0, every output is 0.
- Enables and flushes are combinational from state and inputs. State updates on posedge clk.
- freeze = mem_req & ~mem_ready. Freeze has top priority in every state:
  - all *_we=0 and all flushes=0
  - int_push=0, int_jump=0
  - FSM and counters hold
  - mem_wait_cnt increments and saturates at all-ones
- load_use = ex_mem_read & ((id_use_src1 & id_rsrc1==ex_rdst) | (id_use_src2 & id_rsrc2==ex_rdst)).
- RUN state:
  - Default: all we=1, flushes=0.
  - branch_taken (no freeze): pc_we=1, ifid_flush=1, idex_flush=1.
  - load_use and no branch_taken: pc_we=0, ifid_we=0, idex_flush=1. This is a one-cycle bubble.
  - branch_taken and load_use together: branch wins; the load-use consumer is wrong-path.
  - int_req=1 or int_pending=1, no freeze: transition to DRAIN with counter=0. This cycle still behaves as a normal RUN cycle.
- DRAIN state:
  - pc_we=0, ifid_flush=1. Other buffers advance.
  - If branch_taken: pc_we=1 and idex_flush=1, so the PC captures the target as the return address.
  - Counter increments each unfrozen cycle. At DRAIN_DEPTH-1, transition to PUSH with counter=0.
- PUSH state:
  - int_push=1, int_push_idx=counter.
  - pc_we=0, ifid_flush=1, idex_flush=1. exmem_we and memwb_we stay 1.
  - After PUSH_CYCLES unfrozen cycles, transition to JUMP.
- JUMP state: exactly one cycle with int_jump=1, int_ack=1, pc_we=1, ifid_flush=1, idex_flush=1. Then return to RUN.
- int_req asserted outside RUN sets int_pending. int_pending clears when DRAIN is entered. Back-to-back requests are serviced sequentially and never dropped.
- Load-use is ignored outside RUN, because the ID stage holds bubbles there.
- rst asserted mid-sequence aborts immediately. No partial push is completed.

Test Plan:
- Load-use: ex_mem_read=1, ex_rdst=3, id_rsrc1=3, id_use_src1=1 for one cycle -> pc_we=0, ifid_we=0, idex_flush=1 that cycle only; next cycle all we=1.
- Branch plus load-use in the same cycle: branch_taken=1 with the hazard above -> pc_we=1, ifid_flush=1, idex_flush=1, ifid_we=1.
- Memory freeze: mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1 -> all we=0 for 4 cycles, mem_wait_cnt=4, normal enables on the 5th cycle. Also run 300 freeze cycles -> mem_wait_cnt=255.
- Interrupt with defaults: int_req pulse in RUN -> 3 DRAIN cycles (pc_we=0, ifid_flush=1), then 2 PUSH cycles (int_push_idx 0 then 1), then 1 JUMP cycle (int_jump=int_ack=1), then RUN.
- Freeze during PUSH: mem_req=1, mem_ready=0 for 2 cycles at PUSH idx=1 -> int_push=0 and idx held while frozen; resumes at idx=1; total JUMP delayed by exactly 2 cycles.
- Second interrupt and reset: int_req pulse during PUSH -> after JUMP, one RUN cycle, then a second full sequence. Separately, rst=0 during DRAIN -> all outputs 0 asynchronously; after release, state is RUN with all we=1 and no pending interrupt.
